// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared memory-arbiter types and widths
package proc_pkg;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 64;

  // Records which access the memory is returning data for this cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IF    = 2'd1,
    S_DM_RD = 2'd2,
    S_DM_WR = 2'd3
  } mem_arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and data stages
module mem_port_arbiter
  import proc_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int DATA_W       = MEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  mem_arb_state_t   state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic             if_starved;

  assign if_starved = (starve_cnt == CNT_MAX);

  // Data normally wins; a fetch that has waited STARVE_LIMIT cycles overrides it.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!reset) begin
      if (if_req && if_starved) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!if_req || if_gnt) begin
      starve_cnt_nxt = '0;
    end else if (!if_starved) begin
      starve_cnt_nxt = starve_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    if (if_gnt) begin
      state_nxt = S_IF;
    end else if (dm_gnt) begin
      state_nxt = dm_we ? S_DM_WR : S_DM_RD;
    end
  end

  // Reset discards any read in flight by returning to idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  assign if_rvalid = (state == S_IF);
  assign dm_rvalid = (state == S_DM_RD);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule
